// File: rtl/dual_branch_predictor_if.sv
// Dual-issue branch predictor bus.
// Groups the fetch-side lookup (PC_fetch_n -> prediction_n), the execute-side
// resolution (BranchExecute_n, PC_execute_n, actual_prediction_n, prediction_ex_n)
// and the statistics outputs (branch_count, mispredict_count).
// master: the pipeline driving lookups/resolutions; slave: the predictor.
interface dual_branch_predictor_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [31:0]          PC_fetch_1;
    logic [31:0]          PC_fetch_2;
    logic                 prediction_1;
    logic                 prediction_2;
    logic                 BranchExecute_1;
    logic                 BranchExecute_2;
    logic [31:0]          PC_execute_1;
    logic [31:0]          PC_execute_2;
    logic                 actual_prediction_1;
    logic                 actual_prediction_2;
    logic                 prediction_ex_1;
    logic                 prediction_ex_2;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport master (
        output PC_fetch_1, PC_fetch_2,
        input  prediction_1, prediction_2,
        output BranchExecute_1, BranchExecute_2,
        output PC_execute_1, PC_execute_2,
        output actual_prediction_1, actual_prediction_2,
        output prediction_ex_1, prediction_ex_2,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  PC_fetch_1, PC_fetch_2,
        output prediction_1, prediction_2,
        input  BranchExecute_1, BranchExecute_2,
        input  PC_execute_1, PC_execute_2,
        input  actual_prediction_1, actual_prediction_2,
        input  prediction_ex_1, prediction_ex_2,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/dual_branch_predictor.sv
// Two-slot bimodal branch predictor.
// A table of 2^INDEX_BITS two-bit saturating counters indexed by PC[INDEX_BITS+1:2].
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous active-high reset (table -> weak-NT, counters -> 0)
//   bus   - dual_branch_predictor_if.slave: combinational predictions for two fetch
//           PCs, counter updates from two resolving branches, and registered
//           saturating branch / mispredict statistics.
module dual_branch_predictor #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic                     clk,
    input logic                     reset,
    dual_branch_predictor_if.slave  bus
);
    localparam int unsigned Entries = 1 << INDEX_BITS;

    logic [1:0]            table_q [Entries];
    logic [1:0]            table_d [Entries];
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] fetch_idx_1, fetch_idx_2;
    logic [INDEX_BITS-1:0] exec_idx_1, exec_idx_2;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    assign fetch_idx_1 = bus.PC_fetch_1[INDEX_BITS+1:2];
    assign fetch_idx_2 = bus.PC_fetch_2[INDEX_BITS+1:2];
    assign exec_idx_1  = bus.PC_execute_1[INDEX_BITS+1:2];
    assign exec_idx_2  = bus.PC_execute_2[INDEX_BITS+1:2];

    // Lookups read the registered table, so a same-cycle update is not bypassed.
    assign bus.prediction_1 = table_q[fetch_idx_1][1];
    assign bus.prediction_2 = table_q[fetch_idx_2][1];

    // Slot 2 steps from the slot-1 result, so a shared index gets both steps in order
    // and distinct indices are updated independently.
    always_comb begin
        table_d = table_q;
        if (bus.BranchExecute_1) begin
            table_d[exec_idx_1] = sat_step(table_q[exec_idx_1], bus.actual_prediction_1);
        end
        if (bus.BranchExecute_2) begin
            table_d[exec_idx_2] = sat_step(table_d[exec_idx_2], bus.actual_prediction_2);
        end
    end

    logic [1:0] branch_inc, mispred_inc;
    logic       mispred_1, mispred_2;

    always_comb begin
        mispred_1     = bus.BranchExecute_1 &
                        (bus.prediction_ex_1 ^ bus.actual_prediction_1);
        mispred_2     = bus.BranchExecute_2 &
                        (bus.prediction_ex_2 ^ bus.actual_prediction_2);
        branch_inc    = {1'b0, bus.BranchExecute_1} + {1'b0, bus.BranchExecute_2};
        mispred_inc   = {1'b0, mispred_1} + {1'b0, mispred_2};
        branch_cnt_d  = sat_add(branch_cnt_q, branch_inc);
        mispred_cnt_d = sat_add(mispred_cnt_q, mispred_inc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Entries; i++) begin
                table_q[i] <= 2'b01;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            table_q       <= table_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispred_cnt_q;

    // PC bits outside the index field do not affect prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.PC_fetch_1[31:INDEX_BITS+2], bus.PC_fetch_1[1:0],
                              bus.PC_fetch_2[31:INDEX_BITS+2], bus.PC_fetch_2[1:0],
                              bus.PC_execute_1[31:INDEX_BITS+2], bus.PC_execute_1[1:0],
                              bus.PC_execute_2[31:INDEX_BITS+2], bus.PC_execute_2[1:0]};
endmodule

// File: tb/tb_dual_branch_predictor.sv
module tb_dual_branch_predictor;
    logic clk = 1'b0;
    logic reset;

    dual_branch_predictor_if #(.CNT_WIDTH(16)) bus ();

    dual_branch_predictor #(
        .INDEX_BITS (4),
        .CNT_WIDTH  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers per entry, 0..3, prediction = value >= 2.
    int model_tbl [16];
    int model_br;
    int model_mis;
    int n_cmp = 0;
    int n_err = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_tbl[i] = 1;
        model_br  = 0;
        model_mis = 0;
    endtask

    // One clock cycle: drive inputs, optionally check lookups before the edge
    // (pre-update values), advance the model on the edge, optionally check counters.
    task automatic cycle(input logic rst, input logic chk,
                         input logic [31:0] pf1, input logic [31:0] pf2,
                         input logic be1, input logic [31:0] pe1, input logic a1, input logic p1,
                         input logic be2, input logic [31:0] pe2, input logic a2, input logic p2);
        int i1, i2;
        reset                   = rst;
        bus.PC_fetch_1          = pf1;
        bus.PC_fetch_2          = pf2;
        bus.BranchExecute_1     = be1;
        bus.PC_execute_1        = pe1;
        bus.actual_prediction_1 = a1;
        bus.prediction_ex_1     = p1;
        bus.BranchExecute_2     = be2;
        bus.PC_execute_2        = pe2;
        bus.actual_prediction_2 = a2;
        bus.prediction_ex_2     = p2;
        #1;
        if (chk) begin
            check("pred1", {31'b0, bus.prediction_1}, {31'b0, model_tbl[idx_of(pf1)] >= 2});
            check("pred2", {31'b0, bus.prediction_2}, {31'b0, model_tbl[idx_of(pf2)] >= 2});
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            i1 = idx_of(pe1);
            i2 = idx_of(pe2);
            if (be1) model_tbl[i1] = a1 ? ((model_tbl[i1] < 3) ? model_tbl[i1] + 1 : 3)
                                        : ((model_tbl[i1] > 0) ? model_tbl[i1] - 1 : 0);
            if (be2) model_tbl[i2] = a2 ? ((model_tbl[i2] < 3) ? model_tbl[i2] + 1 : 3)
                                        : ((model_tbl[i2] > 0) ? model_tbl[i2] - 1 : 0);
            model_br  += int'(be1) + int'(be2);
            model_mis += int'(be1 && (a1 != p1)) + int'(be2 && (a2 != p2));
            if (model_br > 65535) model_br = 65535;
            if (model_mis > 65535) model_mis = 65535;
        end
        #1;
        if (chk) begin
            check("branch_count", {16'b0, bus.branch_count}, model_br[31:0]);
            check("mispredict_count", {16'b0, bus.mispredict_count}, model_mis[31:0]);
        end
    endtask

    task automatic idle(input logic [31:0] pf1, input logic [31:0] pf2);
        cycle(1'b0, 1'b1, pf1, pf2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset with garbage updates applied; the first lookup is unchecked (table unknown).
        cycle(1'b1, 1'b0, 32'h0, 32'h4, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(32'h00, 32'h04);
        check("reset_pred1_const", {31'b0, bus.prediction_1}, 32'd0);
        check("reset_bcnt_const", {16'b0, bus.branch_count}, 32'd0);

        // Slot 1 resolves PC 0x10 taken twice; second cycle sees the first update.
        cycle(1'b0, 1'b1, 32'h10, 32'h50, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h10, 32'h50, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("req036_bcnt", {16'b0, bus.branch_count}, 32'd2);
        check("req036_mcnt", {16'b0, bus.mispredict_count}, 32'd1);
        idle(32'h10, 32'h50);
        check("req036_pred", {31'b0, bus.prediction_1}, 32'd1);

        // Bring entry of 0x20 to strong-T, then both slots T/NT in one cycle -> weak-T.
        cycle(1'b0, 1'b1, 32'h20, 32'h24, 1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h20, 32'h24, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1);
        check("req037_entry", 32'(dut.table_q[8]), 32'd2);
        idle(32'h20, 32'h24);
        check("req037_pred", {31'b0, bus.prediction_1}, 32'd1);
        // Same index NT then T from strong-NT path: drive entry 9 down then NT,T -> 01.
        cycle(1'b0, 1'b1, 32'h24, 32'h24, 1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h24, 32'h24, 1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 32'h24, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h24, 32'h24, 1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 1'b1);
        check("same_idx_nt_t", 32'(dut.table_q[9]), 32'd1);

        // Aliasing: 0x48 shares entry 2 with 0x08.
        cycle(1'b0, 1'b1, 32'h08, 32'h48, 1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(32'h08, 32'h0C);
        check("alias_pred", {31'b0, bus.prediction_1}, 32'd1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), 1'b1,
                  $urandom, $urandom,
                  1'($urandom), {$urandom_range(0, 63), 2'b00}, 1'($urandom), 1'($urandom),
                  1'($urandom), {$urandom_range(0, 63), 2'b00}, 1'($urandom), 1'($urandom));
        end

        // Reset concurrent with two updates.
        cycle(1'b1, 1'b1, 32'h10, 32'h20, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
        check("rst_upd_bcnt", {16'b0, bus.branch_count}, 32'd0);
        idle(32'h10, 32'h20);
        check("rst_upd_pred2", {31'b0, bus.prediction_2}, 32'd0);

        // Preload both counters to 0xFFFE, then saturate.
        for (int n = 0; n < 32767; n++) begin
            cycle(1'b0, 1'b0, 32'h0, 32'h4, 1'b1, 32'h30, 1'b1, 1'b0, 1'b1, 32'h34, 1'b0, 1'b1);
        end
        idle(32'h30, 32'h34);
        check("preload_mcnt", {16'b0, bus.mispredict_count}, 32'hFFFE);
        cycle(1'b0, 1'b1, 32'h30, 32'h34, 1'b1, 32'h30, 1'b1, 1'b0, 1'b1, 32'h34, 1'b0, 1'b1);
        check("sat_mcnt", {16'b0, bus.mispredict_count}, 32'hFFFF);
        check("sat_bcnt", {16'b0, bus.branch_count}, 32'hFFFF);
        cycle(1'b0, 1'b1, 32'h30, 32'h34, 1'b1, 32'h30, 1'b1, 1'b0, 1'b1, 32'h34, 1'b0, 1'b1);
        check("sat_hold_mcnt", {16'b0, bus.mispredict_count}, 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dual_branch_predictor.md
DUAL_BRANCH_PREDICTOR -- requirements
Module: dual_branch_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 4, log2 of pattern-table entries (16 entries).
REQ-002 Parameter CNT_WIDTH, default 16, width of statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PC_fetch_1  input  32  fetch PC of issue slot 1.
REQ-006 PC_fetch_2  input  32  fetch PC of issue slot 2.
REQ-007 prediction_1  output  1  taken prediction for slot 1; 1 = taken.
REQ-008 prediction_2  output  1  taken prediction for slot 2; 1 = taken.
REQ-009 BranchExecute_1  input  1  slot-1 branch resolving in execute this cycle.
REQ-010 BranchExecute_2  input  1  slot-2 branch resolving in execute this cycle.
REQ-011 PC_execute_1  input  32  PC of resolving slot-1 branch.
REQ-012 PC_execute_2  input  32  PC of resolving slot-2 branch.
REQ-013 actual_prediction_1  input  1  resolved outcome, slot 1; 1 = taken.
REQ-014 actual_prediction_2  input  1  resolved outcome, slot 2; 1 = taken.
REQ-015 prediction_ex_1  input  1  prediction carried down pipe with slot-1 branch.
REQ-016 prediction_ex_2  input  1  prediction carried down pipe with slot-2 branch.
REQ-017 branch_count  output  CNT_WIDTH  resolved branches since reset.
REQ-018 mispredict_count  output  CNT_WIDTH  mispredicted branches since reset.

Function
REQ-019 Table: 2^INDEX_BITS 2-bit saturating counters; index = PC[INDEX_BITS+1:2].
REQ-020 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = counter MSB.
REQ-021 prediction_1/2: combinational read of the entry indexed by PC_fetch_1/2; zero-cycle latency.
REQ-022 Lookup in the same cycle as an update to that entry returns the pre-update value (no bypass); new value visible the following cycle.
REQ-023 Update when BranchExecute_n=1: actual=1 -> counter+1, saturating at 11; actual=0 -> counter-1, saturating at 00.
REQ-024 BranchExecute_n=0: slot n's actual_prediction, prediction_ex, PC_execute ignored; no table or statistics change.
REQ-025 Both slots update distinct indices in the same cycle: both applied independently.
REQ-026 Both slots update the same index: slot-1 step applied first, slot-2 step applied to that result, single write (e.g. 11 with T,NT -> 10; 00 with NT,T -> 01; 01 with T,T -> 11).
REQ-027 branch_count increments by BranchExecute_1 + BranchExecute_2 (0, 1 or 2) per cycle.
REQ-028 mispredict_count increments by count of slots with BranchExecute_n=1 and prediction_ex_n != actual_prediction_n.
REQ-029 Statistics counters saturate at all-ones; an increment of 2 from all-ones minus 1 yields all-ones; no wrap.
REQ-030 Outputs branch_count/mispredict_count are registered; reflect updates one cycle after the resolving cycle.

Reset
REQ-031 reset=1 at a clock edge sets every table entry to 01 (weak-NT) and both statistics counters to 0.
REQ-032 reset takes priority over any simultaneous update; updates presented during reset are discarded.
REQ-033 While table is at reset values, prediction_1 = prediction_2 = 0 for any PC.
REQ-034 Reset asserted mid-operation returns all state to REQ-031 values on that edge; no partial update.

Verification
REQ-035 Reset, PC_fetch_1=0x00, PC_fetch_2=0x04 -> prediction_1=0, prediction_2=0, both counts 0.
REQ-036 Slot 1 resolves PC 0x10 taken, prediction_ex_1=0, two consecutive cycles -> entry 4 goes 01->10->11; prediction for PC 0x10 =1 from the cycle after the first update; branch_count=2, mispredict_count=1 (second cycle prediction_ex_1=1).
REQ-037 Both slots resolve PC 0x20 in one cycle, entry at 11, slot1 T, slot2 NT -> entry 10, prediction stays 1, branch_count +2.
REQ-038 Aliasing: PC 0x08 and 0x48 (INDEX_BITS=4) share entry 2; update via 0x48 changes prediction for 0x08.
REQ-039 Preload mispredict_count to 0xFFFE via repeated mispredicts, then two-slot mispredict cycle -> 0xFFFF, stays 0xFFFF afterward.
REQ-040 Reset asserted in same cycle as two updates -> table all 01, counts 0 next cycle.
